// File: rtl/pri_encoder_arb_n_pkg.sv
// rtl/pri_encoder_arb_n_pkg.sv - shared types, limits and index helper for pri_encoder_arb_n
package pri_enc_pkg;

    // Largest supported request vector and the index width it needs
    localparam int MAX_N = 256;
    localparam int MAX_W = $clog2(MAX_N);

    // Output register state: EMPTY holds no grant, FULL presents one
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Binary index of a one-hot vector; a zero vector maps to index 0
    function automatic logic [MAX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri_encoder_arb_n_if.sv
// rtl/pri_encoder_arb_n_if.sv - request/grant bundle between requesters, arbiter and consumer
interface pri_encoder_arb_n_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         any_req;

    // Requesters and consumer side
    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  any_req
    );

    // Arbiter side
    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output any_req
    );

endinterface

// File: rtl/pri_encoder_arb_n_find.sv
// rtl/pri_encoder_arb_n_find.sv - combinational circular-downward request finder
module pri_find_n
    import pri_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [MAX_N-1:0] hit;

    // Walk start, start-1, ..., 0, N-1, ..., start+1 and mark the first set request
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int pos;
            pos = (int'(start) >= i) ? (int'(start) - i) : (int'(start) + N - i);
            if (!found && req[pos]) begin
                found    = 1'b1;
                hit[pos] = 1'b1;
            end
        end
        idx = W'(onehot_to_idx(hit));
    end

endmodule

// File: rtl/pri_encoder_arb_n.sv
// rtl/pri_encoder_arb_n.sv - registered priority encoder/arbiter, round-robin when PRI_ENC_ARB_RR_EN is defined
module pri_encoder_arb_n
    import pri_enc_pkg::*;
#(
    parameter int N = 8
) (
    input logic              clk,
    input logic              rst_n,
    pri_encoder_arb_n_if.slave bus
);

    localparam int           W    = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    arb_state_e   state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] oh_q, oh_d;
    logic         accept;
    logic         load;
    logic         found;
    logic [W-1:0] start;
    logic [W-1:0] win_idx;

    assign accept = (state_q == FULL) && bus.out_ready;
    assign load   = (state_q == EMPTY) || accept;

`ifdef PRI_ENC_ARB_RR_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_after;

    // The just-accepted index becomes lowest priority; the search on the
    // accepting edge already uses the rotated pointer so grants never repeat early
    assign ptr_after = (idx_q == '0) ? LAST : (idx_q - W'(1));
    assign start     = accept ? ptr_after : ptr_q;

    // Priority pointer advances only when the consumer takes a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= LAST;
        end else if (accept) begin
            ptr_q <= ptr_after;
        end
    end
`else
    assign start = LAST;
`endif

    pri_find_n #(
        .N (N)
    ) u_find (
        .req   (bus.req),
        .start (start),
        .found (found),
        .idx   (win_idx)
    );

    // Next grant: load a winner or go empty on load edges, otherwise freeze
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        if (load) begin
            if (found) begin
                state_d = FULL;
                idx_d   = win_idx;
                oh_d    = ONE << win_idx;
            end else begin
                state_d = EMPTY;
                oh_d    = '0;
            end
        end
    end

    // Grant registers; reset drops any pending grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
        end
    end

    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = oh_q;
    assign bus.any_req    = |bus.req;

endmodule

// File: doc/pri_encoder_arb_n.md
# pri_encoder_arb_n

Parametrised, registered priority encoder and arbiter for N request lines, sampled on a single clock. It returns the winning request index on a valid/ready handshake and holds that index stable until the consumer accepts it. The default priority is fixed, with the highest index winning, which matches the team's 8x3 combinational encoder truth table. An optional round-robin mode rotates priority after each accepted grant. The block sits between request sources (interrupt lines, channel requests) and a single consumer that services one index at a time.

## Interface
- `N`, default 8: number of request lines; legal range 2..256.
- `W`, default `$clog2(N)`: index width; derived, not to be overridden.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `req`, in, N: level request vector; bit i = requester i.
- `out_valid`, out, 1: `out_idx`/`out_onehot` hold a grant.
- `out_ready`, in, 1: consumer accepts the grant when `out_valid && out_ready`.
- `out_idx`, out, W: binary index of the granted requester.
- `out_onehot`, out, N: one-hot form of `out_idx`; all zero when `!out_valid`.
- `any_req`, out, 1: combinational OR of `req`; not registered.

## Operation
- Two states: `EMPTY` (`out_valid`=0) and `FULL` (`out_valid`=1).
- Load condition is `load = (state==EMPTY) || (out_valid && out_ready)`.
- **Loading with requests:** on a load edge with `req != 0`, register the winner, set `out_onehot` to match, and go to (or stay in) `FULL`.
- **Loading with no requests:** on a load edge with `req == 0`, go to `EMPTY`. `out_idx` keeps its last value and `out_onehot` clears to 0.
- **Holding in FULL:** while in `FULL` without acceptance, `out_idx` and `out_onehot` are frozen. Request changes do not retract or alter the grant, including deassertion of the granted bit.
- **Fixed priority (default):** the winner is the highest set index. For example, `req=8'b0010_0110` gives index 5.
- **Round-robin (macro enabled):**
  - `ptr` (W bits) marks the highest-priority position.
  - The search runs downward from `ptr` through 0, then wraps from N-1 down to `ptr+1`.
  - On every accepted grant k, `ptr` becomes k-1, wrapping from 0 to N-1. The granted requester therefore becomes lowest priority.
- Every register resets as follows: `out_valid`=0, `out_idx`=0, `out_onehot`=0, `ptr`=N-1, state=`EMPTY`.
- Indices at or above N never appear, including when N is not a power of two.

## Timing
- Latency: `req` sampled at edge t appears on `out_*` after edge t (1 cycle). There is no combinational path from `req` to `out_valid`/`out_idx`.
- Throughput is one grant per cycle. Back-to-back acceptance with `req` held nonzero keeps `out_valid` high continuously, and a new index is loaded on each accepting edge.
- `out_ready` asserted in `EMPTY` has no effect.
- A single-cycle `req` pulse is captured only if it coincides with a load edge. Pulses during `FULL` are not latched.
- **Reset mid-operation:** assertion of `rst_n` clears `out_valid` immediately (asynchronously) and discards any pending grant. The first load happens on the first edge after deassertion.
- `ptr` updates only on the accept edge, never on the load-from-`EMPTY` edge.

## Configuration
- `PRI_ENC_ARB_RR_EN`
  - **Defined:** round-robin arbitration, `ptr` register present, `ptr` updated on accept.
  - **Undefined:** fixed highest-index priority; `ptr` and its update logic are not compiled in.
  - Port list is identical in both builds.

## Structure
- Package `pri_enc_pkg` holds:
  - the state typedef (`EMPTY`, `FULL`);
  - the `MAX_N`=256 constant;
  - a function `onehot_to_idx` used by the RTL and the bench model.
- Sub-module `pri_find_n` is a combinational masked finder parametrised by N. It takes a request vector and a start position and returns the found flag and index. It is instantiated once; fixed mode ties the start position to N-1.

## Test plan
- **Reset and basic grant:** reset, then `req=8'h26` and `out_ready=0`. Required: `out_valid`=1 after 1 edge with `out_idx`=5 and `out_onehot`=8'h20, held for 10 cycles while `req` changes to 8'h01.
- **Drain, fixed mode:** `req=8'h81` held, `out_ready=1`. Required: fixed build gives `out_idx`=7 every cycle with `out_valid` continuously high. RR build alternates 7, 0, 7, 0.
- **RR rotation:** RR build, `req=8'hFF`, `out_ready=1`. Required: grant sequence 7, 6, 5, …, 0, 7 with no gaps.
- **Empty transition:** grant index 3 with `req=8'h08`, then drop `req` to 0 and accept. Required: `out_valid`=0 and `out_onehot`=0 next cycle, and `any_req`=0 in the same cycle.
- **Non-power-of-two width:** N=5, `req=5'b10000`. Required: `out_idx`=4. In the RR build after accepting 0, `ptr`=4.
- **Asynchronous reset:** assert `rst_n`=0 mid-cycle while `FULL`. Required: `out_valid` drops before the next edge. After release with `req=8'h02`, the grant is index 1 one edge later.
